// File: rtl/sync_fifo_pkg.sv
// Shared constants and depth helper for the
// single-clock FIFO.
package sync_fifo_pkg;

    localparam int DATA_WIDTH_DEF = 4;
    localparam int BUF_WIDTH_DEF  = 3;

    function automatic int depth_of(input int bw);
        return 1 << bw;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_WIDTH register array, one
// synchronous write port, one registered read port.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int BUF_WIDTH  = BUF_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [BUF_WIDTH-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  re,
    input  logic [BUF_WIDTH-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = depth_of(BUF_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is never cleared; pointers make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (re) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy count
// and status flag decode around sync_fifo_mem.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int BUF_WIDTH  = BUF_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] buf_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] buf_out,
    output logic                  buf_empty,
    output logic                  buf_full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [BUF_WIDTH:0]    fifo_counter
);

    localparam int CNT_W = BUF_WIDTH + 1;
    localparam int DEPTH = depth_of(BUF_WIDTH);

    localparam logic [BUF_WIDTH:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [BUF_WIDTH:0] CNT_AFULL = CNT_W'(DEPTH - 1);
    localparam logic [BUF_WIDTH:0] CNT_ONE   = CNT_W'(1);

    logic [BUF_WIDTH-1:0] wr_ptr;
    logic [BUF_WIDTH-1:0] rd_ptr;
    logic                 wr_ok;
    logic                 rd_ok;

    assign buf_empty    = (fifo_counter == '0);
    assign buf_full     = (fifo_counter == CNT_FULL);
    assign almost_empty = (fifo_counter == CNT_ONE);
    assign almost_full  = (fifo_counter == CNT_AFULL);

    // Full blocks writes and empty blocks reads, so a
    // simultaneous request at either limit degrades to one op.
    assign wr_ok = wr_en && !buf_full;
    assign rd_ok = rd_en && !buf_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_counter <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   fifo_counter <= fifo_counter + 1'b1;
                2'b01:   fifo_counter <= fifo_counter - 1'b1;
                default: fifo_counter <= fifo_counter;
            endcase
        end
    end

    sync_fifo_mem #(
        .BUF_WIDTH  (BUF_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we      (wr_ok && !rst),
        .wr_addr (wr_ptr),
        .wr_data (buf_in),
        .re      (rd_ok),
        .rd_addr (rd_ptr),
        .rd_data (buf_out)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed + randomized bench for sync_fifo
// against a queue-based reference model.
module tb_sync_fifo;

    localparam int BW    = 3;
    localparam int DW    = 4;
    localparam int DEPTH = 1 << BW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] buf_in = '0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] buf_out;
    logic          buf_empty;
    logic          buf_full;
    logic          almost_empty;
    logic          almost_full;
    logic [BW:0]   fifo_counter;

    int compared   = 0;
    int mismatched = 0;

    logic [DW-1:0] q [$];
    logic [DW-1:0] m_out = '0;

    always #5 clk = ~clk;

    sync_fifo #(
        .BUF_WIDTH  (BW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .buf_in       (buf_in),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .buf_out      (buf_out),
        .buf_empty    (buf_empty),
        .buf_full     (buf_full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .fifo_counter (fifo_counter)
    );

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        check({tag, ":buf_out"}, 32'(buf_out), 32'(m_out));
        check({tag, ":count"}, 32'(fifo_counter), 32'(n));
        check({tag, ":empty"}, 32'(buf_empty), 32'(n == 0));
        check({tag, ":full"}, 32'(buf_full), 32'(n == DEPTH));
        check({tag, ":aempty"}, 32'(almost_empty), 32'(n == 1));
        check({tag, ":afull"}, 32'(almost_full),
              32'(n == DEPTH - 1));
    endtask

    // One clock: drive, update the model from pre-edge state, check.
    task automatic step(input logic r, input logic w,
                        input logic rd, input logic [DW-1:0] d,
                        input string tag);
        bit do_w;
        bit do_r;
        rst    = r;
        wr_en  = w;
        rd_en  = rd;
        buf_in = d;
        do_w   = w && (q.size() < DEPTH);
        do_r   = rd && (q.size() > 0);
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            m_out = '0;
        end else begin
            if (do_r) m_out = q.pop_front();
            if (do_w) q.push_back(d);
        end
        check_all(tag);
    endtask

    logic [DW-1:0] seq [8];

    initial begin
        seq = '{4'd10, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};

        step(1, 0, 0, 0, "reset");
        step(0, 0, 0, 0, "idle");

        step(0, 1, 0, 4'd1, "push1");
        check("push1_aempty", 32'(almost_empty), 32'd1);
        check("push1_out", 32'(buf_out), 32'd0);

        step(0, 1, 1, 4'd2, "push2_pop");
        check("pp_out", 32'(buf_out), 32'd1);
        check("pp_cnt", 32'(fifo_counter), 32'd1);
        step(0, 0, 1, 0, "pop2");
        check("pop2_out", 32'(buf_out), 32'd2);

        // simultaneous on empty: write only
        step(0, 1, 1, 4'd9, "both_empty");
        check("both_empty_out", 32'(buf_out), 32'd2);
        step(0, 0, 1, 0, "pop9");

        for (int i = 0; i < 7; i++) step(0, 1, 0, seq[i], "fill");
        check("afull7", 32'(almost_full), 32'd1);
        step(0, 1, 0, seq[7], "fill8");
        check("full8", 32'(buf_full), 32'd1);
        step(0, 1, 0, 4'd9, "push_full");
        check("push_full_cnt", 32'(fifo_counter), 32'd8);

        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 0, "drain");
            check("drain_val", 32'(buf_out), 32'(seq[i]));
        end
        check("drained_empty", 32'(buf_empty), 32'd1);
        step(0, 0, 1, 0, "pop_empty");
        check("pop_empty_out", 32'(buf_out), 32'd8);

        // simultaneous on full: read only
        for (int i = 0; i < 8; i++) step(0, 1, 0, 4'(i), "refill");
        step(0, 1, 1, 4'hF, "both_full");
        check("both_full_cnt", 32'(fifo_counter), 32'd7);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0, "drain2");

        // wrap: 3 pushes then 3 pops, repeated
        for (int c = 0; c < 21; c++) begin
            if ((c / 3) % 2 == 0)
                step(0, 1, 0, 4'($urandom), "wrap_push");
            else
                step(0, 0, 1, 0, "wrap_pop");
            check("wrap_range", 32'(fifo_counter <= 3), 32'd1);
        end

        for (int i = 0; i < 5; i++) step(0, 1, 0, 4'(i + 3), "pre_rst");
        step(1, 1, 1, 4'hE, "mid_rst");
        check("mid_rst_cnt", 32'(fifo_counter), 32'd0);
        check("mid_rst_out", 32'(buf_out), 32'd0);
        step(0, 1, 0, 4'hC, "post_push");
        step(0, 0, 1, 0, "post_pop");
        check("post_pop_out", 32'(buf_out), 32'hC);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 99) < 55),
                 ($urandom_range(0, 99) < 45),
                 4'($urandom), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
